// File: rtl/jimktrains_vslc_pkg.sv
// Shared constants and types for the very simple logic controller.
// No logic of its own; opcodes, SPI framing, timer/servo constants and pin map.
// Types carry single-cycle command pulses from exec to the timer/servo blocks.
package vslc_pkg;

  // Opcodes live in byte[7:4]
  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_PUSH_IN  = 4'h1;
  localparam logic [3:0] OP_PUSH_OUT = 4'h2;
  localparam logic [3:0] OP_STORE    = 4'h3;
  localparam logic [3:0] OP_AND      = 4'h4;
  localparam logic [3:0] OP_OR       = 4'h5;
  localparam logic [3:0] OP_XOR      = 4'h6;
  localparam logic [3:0] OP_NOT      = 4'h7;
  localparam logic [3:0] OP_PUSH_LIT = 4'h8;
  localparam logic [3:0] OP_DUP      = 4'h9;
  localparam logic [3:0] OP_DROP     = 4'hA;
  localparam logic [3:0] OP_TON      = 4'hB;
  localparam logic [3:0] OP_SERVO    = 4'hC;
  localparam logic [3:0] OP_END      = 4'hF;

  // SPI flash READ command, followed by a 24-bit zero address
  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam int         SPI_ADDR_BITS = 24;

  // Servo frame: 200 ticks, pulse width depends on the 1-bit position
  localparam int SERVO_PERIOD  = 200;
  localparam int SERVO_PULSE_0 = 10;
  localparam int SERVO_PULSE_1 = 20;

  // uio pin map
  localparam int         UIO_CS_N   = 0;
  localparam int         UIO_MOSI   = 1;
  localparam int         UIO_MISO   = 2;
  localparam int         UIO_SCK    = 3;
  localparam int         UIO_SERVO0 = 4;
  localparam int         UIO_SERVO1 = 5;
  localparam logic [7:0] UIO_OE     = 8'h3B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_STREAM
  } fetch_state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
    logic [1:0] sel;
    logic       en;
  } timer_cmd_t;

  typedef struct packed {
    logic vld;
    logic idx;
    logic pos;
  } servo_cmd_t;

  // Timer preset table selected by byte[3:2]
  function automatic logic [7:0] timer_preset(input logic [1:0] sel);
    logic [7:0] p;
    case (sel)
      2'd0:    p = 8'd10;
      2'd1:    p = 8'd50;
      2'd2:    p = 8'd100;
      default: p = 8'd250;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/jimktrains_vslc_core.sv
// SPI instruction fetch (mode 0 READ from address 0), timers, servos and executor.
// Latency: byte executes one clock after its 8th MISO sample; END returns to IDLE.
// No backpressure: SCK free-runs while streaming and execution never stalls it.
module vslc_core
  import vslc_pkg::*;
#(
  parameter int SPI_CLK_DIV   = 4,
  parameter int TIMER_CLK_DIV = 9999,
  parameter int SERVO_CLK_DIV = 999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic       miso,
  output logic [7:0] uo_out,
  output logic       cs_n,
  output logic       mosi,
  output logic       sck,
  output logic [1:0] servo
);

  fetch_state_t    state, state_nxt;
  logic            idle_cnt;
  logic [15:0]     spi_div;
  logic [4:0]      bit_cnt;
  logic [31:0]     tx_sr;
  logic [6:0]      rx_sr;
  logic [2:0]      rx_cnt;
  logic            byte_vld;
  logic [7:0]      byte_dat;
  logic            spi_edge, spi_rise, spi_fall;
  logic            end_scan;
  timer_cmd_t      timer_cmd;
  servo_cmd_t      servo_cmd;
  logic [15:0]     timer_div, servo_div;
  logic            timer_tick, servo_tick;
  logic [3:0]      tmr_en;
  logic [3:0][7:0] tmr_cnt;
  logic [3:0][1:0] tmr_sel;
  logic [7:0]      servo_cnt;
  logic [1:0]      pos_pend, pos_act;

  assign spi_edge   = (state != S_IDLE) && (spi_div == 16'(SPI_CLK_DIV));
  assign spi_rise   = spi_edge && !sck;
  assign spi_fall   = spi_edge && sck;
  assign timer_tick = (timer_div == 16'(TIMER_CLK_DIV));
  assign servo_tick = (servo_div == 16'(SERVO_CLK_DIV));
  assign cs_n       = (state == S_IDLE);
  assign mosi       = tx_sr[31];

  // Free-running tick prescalers for timers and servos
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_div <= '0;
      servo_div <= '0;
    end else begin
      timer_div <= timer_tick ? '0 : timer_div + 16'd1;
      servo_div <= servo_tick ? '0 : servo_div + 16'd1;
    end
  end

  // Fetch FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Fetch FSM next state: command and address phases counted on SCK falls
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (idle_cnt) state_nxt = S_CMD;
      S_CMD:    if (spi_fall && bit_cnt == 5'd7) state_nxt = S_ADDR;
      S_ADDR:   if (spi_fall && bit_cnt == 5'(8 + SPI_ADDR_BITS - 1)) state_nxt = S_STREAM;
      S_STREAM: ;
      default:  state_nxt = S_IDLE;
    endcase
    if (end_scan) state_nxt = S_IDLE;
  end

  // SPI shift datapath: MOSI moves on SCK fall, MISO sampled on SCK rise
  always_ff @(posedge clk) begin
    if (!rst_n || end_scan) begin
      idle_cnt <= 1'b0;
      spi_div  <= '0;
      sck      <= 1'b0;
      bit_cnt  <= '0;
      tx_sr    <= {SPI_CMD_READ, 24'h0};
      rx_sr    <= '0;
      rx_cnt   <= '0;
      byte_vld <= 1'b0;
      byte_dat <= '0;
    end else if (state == S_IDLE) begin
      idle_cnt <= ~idle_cnt;
    end else begin
      spi_div  <= spi_edge ? '0 : spi_div + 16'd1;
      byte_vld <= 1'b0;
      if (spi_edge) sck <= ~sck;
      if (spi_fall && state != S_STREAM) begin
        tx_sr   <= {tx_sr[30:0], 1'b0};
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (spi_rise && state == S_STREAM) begin
        rx_sr  <= {rx_sr[5:0], miso};
        rx_cnt <= rx_cnt + 3'd1;
        if (rx_cnt == 3'd7) begin
          byte_vld <= 1'b1;
          byte_dat <= {rx_sr, miso};
        end
      end
    end
  end

  vslc_exec exec (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_vld  (byte_vld),
    .byte_dat  (byte_dat),
    .ui_in     (ui_in),
    .timer_cnt (tmr_cnt),
    .uo_out    (uo_out),
    .end_scan  (end_scan),
    .timer_cmd (timer_cmd),
    .servo_cmd (servo_cmd)
  );

  // On-delay timers: count while enabled, saturate at preset, clear on disable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_en  <= '0;
      tmr_cnt <= '0;
      tmr_sel <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (timer_tick && tmr_en[i] && tmr_cnt[i] < timer_preset(tmr_sel[i]))
          tmr_cnt[i] <= tmr_cnt[i] + 8'd1;
      end
      if (timer_cmd.vld) begin
        if (timer_cmd.en) begin
          tmr_en[timer_cmd.idx]  <= 1'b1;
          tmr_sel[timer_cmd.idx] <= timer_cmd.sel;
        end else begin
          tmr_en[timer_cmd.idx]  <= 1'b0;
          tmr_cnt[timer_cmd.idx] <= '0;
        end
      end
    end
  end

  // Servo frame counter; new positions are adopted only at frame start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      servo_cnt <= '0;
      pos_pend  <= '0;
      pos_act   <= '0;
    end else begin
      if (servo_cmd.vld) pos_pend[servo_cmd.idx] <= servo_cmd.pos;
      if (servo_tick) begin
        if (servo_cnt == 8'(SERVO_PERIOD - 1)) begin
          servo_cnt <= '0;
          pos_act   <= pos_pend;
        end else begin
          servo_cnt <= servo_cnt + 8'd1;
        end
      end
    end
  end

  // Pulse outputs decoded from the frame counter
  always_comb begin
    servo = '0;
    for (int i = 0; i < 2; i++)
      servo[i] = servo_cnt < (pos_act[i] ? 8'(SERVO_PULSE_1) : 8'(SERVO_PULSE_0));
  end

endmodule

// File: rtl/jimktrains_vslc_exec.sv
// Instruction executor: 16-deep 1-bit stack, output latch, timer/servo commands.
// Latency: one clock per instruction; state updates on the clock after byte_vld rises.
// No backpressure: every valid byte is consumed the cycle it is presented.
module vslc_exec
  import vslc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            byte_vld,
  input  logic [7:0]      byte_dat,
  input  logic [7:0]      ui_in,
  input  logic [3:0][7:0] timer_cnt,
  output logic [7:0]      uo_out,
  output logic            end_scan,
  output timer_cmd_t      timer_cmd,
  output servo_cmd_t      servo_cmd
);

  reg   [15:0] stack;
  logic [15:0] stack_nxt;
  logic [7:0]  uo_nxt;
  logic [3:0]  op;
  logic [2:0]  n;
  logic        tos;
  logic        nos;

  assign op  = byte_dat[7:4];
  assign n   = byte_dat[2:0];
  assign tos = stack[0];
  assign nos = stack[1];

  // Decode the current byte into next stack/output values and side commands
  always_comb begin
    stack_nxt = stack;
    uo_nxt    = uo_out;
    timer_cmd = '0;
    servo_cmd = '0;
    end_scan  = byte_vld && (op == OP_END);
    case (op)
      OP_PUSH_IN:  stack_nxt = {stack[14:0], ui_in[n]};
      OP_PUSH_OUT: stack_nxt = {stack[14:0], uo_out[n]};
      OP_STORE: begin
        uo_nxt[n] = tos;
        stack_nxt = {1'b0, stack[15:1]};
      end
      OP_AND:      stack_nxt = {1'b0, stack[15:2], tos & nos};
      OP_OR:       stack_nxt = {1'b0, stack[15:2], tos | nos};
      OP_XOR:      stack_nxt = {1'b0, stack[15:2], tos ^ nos};
      OP_NOT:      stack_nxt[0] = ~tos;
      OP_PUSH_LIT: stack_nxt = {stack[14:0], byte_dat[0]};
      OP_DUP:      stack_nxt = {stack[14:0], tos};
      OP_DROP:     stack_nxt = {1'b0, stack[15:1]};
      OP_TON: begin
        // Done is reported from the counter value before any same-cycle tick;
        // a disabled rung reports not-done straight away.
        stack_nxt[0]  = tos & (timer_cnt[byte_dat[1:0]] == timer_preset(byte_dat[3:2]));
        timer_cmd.vld = byte_vld;
        timer_cmd.idx = byte_dat[1:0];
        timer_cmd.sel = byte_dat[3:2];
        timer_cmd.en  = tos;
      end
      OP_SERVO: begin
        stack_nxt     = {1'b0, stack[15:1]};
        servo_cmd.vld = byte_vld;
        servo_cmd.idx = byte_dat[0];
        servo_cmd.pos = tos;
      end
      default: ;
    endcase
  end

  // Commit the decoded instruction; END leaves the stack untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stack  <= '0;
      uo_out <= '0;
    end else if (byte_vld) begin
      stack  <= stack_nxt;
      uo_out <= uo_nxt;
    end
  end

endmodule

// File: rtl/jimktrains_vslc.sv
// TinyTapeout wrapper for the very simple logic controller: pin mapping only.
// Latency: none added; all outputs come straight from the core.
// No backpressure: the tile runs continuously; ena is not used.
module jimktrains_vslc
  import vslc_pkg::*;
#(
  parameter int SPI_CLK_DIV   = 4,
  parameter int TIMER_CLK_DIV = 9999,
  parameter int SERVO_CLK_DIV = 999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       cs_n;
  logic       mosi;
  logic       sck;
  logic [1:0] servo;
  logic       unused_inputs;

  vslc_core #(
    .SPI_CLK_DIV   (SPI_CLK_DIV),
    .TIMER_CLK_DIV (TIMER_CLK_DIV),
    .SERVO_CLK_DIV (SERVO_CLK_DIV)
  ) core (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .miso   (uio_in[UIO_MISO]),
    .uo_out (uo_out),
    .cs_n   (cs_n),
    .mosi   (mosi),
    .sck    (sck),
    .servo  (servo)
  );

  // Map core signals onto the bidirectional pins
  always_comb begin
    uio_out             = '0;
    uio_out[UIO_CS_N]   = cs_n;
    uio_out[UIO_MOSI]   = mosi;
    uio_out[UIO_SCK]    = sck;
    uio_out[UIO_SERVO0] = servo[0];
    uio_out[UIO_SERVO1] = servo[1];
  end

  assign uio_oe        = UIO_OE;
  assign unused_inputs = ^{ena, uio_in[7:3], uio_in[1:0]};

endmodule

// File: tb/tb_jimktrains_vslc.sv
module tb_jimktrains_vslc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       miso = 1'b0;

  always #5 clk = ~clk;
  assign uio_in = {5'b0, miso, 2'b0};

  jimktrains_vslc #(
    .SPI_CLK_DIV   (0),
    .TIMER_CLK_DIV (0),
    .SERVO_CLK_DIV (0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- SPI memory model (drives MISO, captures MOSI) ----------
  logic [7:0]  prog[$];
  logic        prev_sck = 1'b0;
  int          fall_cnt = 0;
  int          rise_cnt = 0;
  logic [31:0] frame    = '0;
  logic        frame_done = 1'b0;
  int          rise1_cyc = 0;
  int          rise2_cyc = 0;

  always @(negedge clk) begin
    logic       cs, sk;
    logic [7:0] b;
    int         pos;
    cs = uio_out[0];
    sk = uio_out[3];
    if (cs) begin
      fall_cnt = 0;
      rise_cnt = 0;
    end else begin
      if (prev_sck && !sk) fall_cnt++;
      if (!prev_sck && sk && rise_cnt < 32) begin
        frame = {frame[30:0], uio_out[1]};
        rise_cnt++;
        if (rise_cnt == 1) rise1_cyc = cyc;
        if (rise_cnt == 2) rise2_cyc = cyc;
        if (rise_cnt == 32) frame_done = 1'b1;
      end
    end
    if (fall_cnt < 32) begin
      miso = 1'b0;
    end else begin
      pos  = fall_cnt - 32;
      b    = (pos / 8 < prog.size()) ? prog[pos / 8] : 8'hFF;
      miso = b[7 - (pos % 8)];
    end
    prev_sck = sk;
  end

  // ---------------- scoreboard: scan results checked at each END -----------
  typedef struct packed {
    logic [7:0]  tag;
    logic [7:0]  uo_mask;
    logic [7:0]  uo_val;
    logic        chk_stack;
    logic [15:0] stack_val;
  } scan_exp_t;

  typedef struct packed {
    logic [7:0] tag;
    int         hi;
    int         period;
  } servo_exp_t;

  scan_exp_t  scan_q[$];
  servo_exp_t servo_q[$];
  logic [7:0] tag_n = 8'd0;
  logic       prev_cs = 1'b1;

  always @(negedge clk) begin
    scan_exp_t e;
    if (rst_n && uio_out[0] && !prev_cs && scan_q.size() > 0) begin
      e = scan_q.pop_front();
      chk($sformatf("scan%0d_uo", e.tag), 32'(uo_out & e.uo_mask), 32'(e.uo_val & e.uo_mask));
      if (e.chk_stack)
        chk($sformatf("scan%0d_stack", e.tag), 32'(dut.core.exec.stack), 32'(e.stack_val));
    end
    prev_cs = uio_out[0];
  end

  // ---------------- servo monitor: high time and period per frame ----------
  logic prev_srv = 1'b0;
  logic have_frame = 1'b0;
  int   hi_cnt = 0;
  int   per_cnt = 0;

  always @(negedge clk) begin
    servo_exp_t e;
    logic       s;
    s = uio_out[4];
    if (!rst_n) begin
      have_frame = 1'b0;
      hi_cnt     = 0;
      per_cnt    = 0;
    end else begin
      if (s && !prev_srv) begin
        if (have_frame && servo_q.size() > 0) begin
          e = servo_q.pop_front();
          chk($sformatf("servo%0d_hi", e.tag), 32'(hi_cnt), 32'(e.hi));
          chk($sformatf("servo%0d_period", e.tag), 32'(per_cnt), 32'(e.period));
        end
        have_frame = 1'b1;
        hi_cnt     = 0;
        per_cnt    = 0;
      end
      per_cnt++;
      if (s) hi_cnt++;
    end
    prev_srv = s;
  end

  // ---------------- stimulus helpers ----------------
  task automatic exp_scan(input logic [7:0] mask, input logic [7:0] val,
                          input logic cs, input logic [15:0] sv);
    scan_exp_t e;
    e.tag = tag_n; e.uo_mask = mask; e.uo_val = val; e.chk_stack = cs; e.stack_val = sv;
    scan_q.push_back(e);
    tag_n++;
  endtask

  task automatic exp_servo(input int hi);
    servo_exp_t e;
    e.tag = tag_n; e.hi = hi; e.period = 200;
    servo_q.push_back(e);
    tag_n++;
  endtask

  task automatic wait_scans(input int budget);
    int k = 0;
    while (scan_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (scan_q.size() != 0) begin
      chk("scan_timeout", 32'(scan_q.size()), 32'd0);
      scan_q.delete();
    end
  endtask

  task automatic wait_servo(input int budget);
    int k = 0;
    while (servo_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (servo_q.size() != 0) begin
      chk("servo_timeout", 32'(servo_q.size()), 32'd0);
      servo_q.delete();
    end
  endtask

  task automatic fill(input logic [7:0] b, input int count);
    for (int i = 0; i < count; i++) prog.push_back(b);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    rst_n = 1'b0;
    ena   = 1'b1;
    ui_in = 8'h00;
    prog.delete();
    fill(8'hFF, 1);

    // Reset state
    repeat (5) @(negedge clk);
    chk("reset_uo", 32'(uo_out), 32'h00);
    chk("reset_cs_n", 32'(uio_out[0]), 32'd1);
    chk("reset_sck", 32'(uio_out[3]), 32'd0);
    chk("reset_mosi", 32'(uio_out[1]), 32'd0);
    chk("reset_oe", 32'(uio_oe), 32'h3B);
    chk("reset_stack", 32'(dut.core.exec.stack), 32'h0000);
    chk("reset_tos", 32'(dut.core.exec.stack[0]), 32'd0);

    // Logic scan plus fetch framing on the first frame
    prog.delete();
    prog.push_back(8'h11); prog.push_back(8'h12); prog.push_back(8'h40);
    prog.push_back(8'h30); prog.push_back(8'hFF);
    ui_in = 8'h06;
    exp_scan(8'h01, 8'h01, 1'b1, 16'h0000);
    frame_done = 1'b0;
    rst_n = 1'b1;
    k = 0;
    while (!frame_done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("frame_seen", 32'(frame_done), 32'd1);
    chk("frame_word", frame, 32'h0300_0000);
    chk("sck_period", 32'(rise2_cyc - rise1_cyc), 32'd2);
    wait_scans(2000);
    ui_in = 8'h02;
    exp_scan(8'h01, 8'h00, 1'b1, 16'h0000);
    wait_scans(2000);

    // Stack overflow then underflow, stack preserved across END
    @(negedge clk);
    rst_n = 1'b0;
    prog.delete();
    fill(8'h81, 17); fill(8'hFF, 1);
    repeat (3) @(negedge clk);
    exp_scan(8'h00, 8'h00, 1'b1, 16'hFFFF);
    rst_n = 1'b1;
    wait_scans(3000);
    prog.delete();
    fill(8'hA0, 17); fill(8'hFF, 1);
    exp_scan(8'h00, 8'h00, 1'b1, 16'h0000);
    wait_scans(3000);

    // Reset in the middle of a streamed byte
    prog.delete();
    fill(8'h81, 17); fill(8'hFF, 1);
    repeat (121) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_stack", 32'(dut.core.exec.stack), 32'h0000);
    chk("midreset_cs_n", 32'(uio_out[0]), 32'd1);
    chk("midreset_sck", 32'(uio_out[3]), 32'd0);

    // Timer 0, preset 10
    prog.delete();
    prog.push_back(8'h81); prog.push_back(8'hB0); prog.push_back(8'h31); prog.push_back(8'hFF);
    exp_scan(8'h02, 8'h00, 1'b1, 16'h0000);
    exp_scan(8'h02, 8'h02, 1'b1, 16'h0000);
    exp_scan(8'h02, 8'h02, 1'b1, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    wait_scans(3000);
    prog[0] = 8'h80;
    exp_scan(8'h02, 8'h00, 1'b1, 16'h0000);
    wait_scans(2000);
    prog[0] = 8'h81;
    exp_scan(8'h02, 8'h00, 1'b1, 16'h0000);
    exp_scan(8'h02, 8'h02, 1'b1, 16'h0000);
    wait_scans(3000);

    // Servo 0 position 1 then position 0
    @(negedge clk);
    rst_n = 1'b0;
    prog.delete();
    prog.push_back(8'h81); prog.push_back(8'hC0); prog.push_back(8'hFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    exp_servo(20);
    wait_servo(1000);
    prog[0] = 8'h80;
    repeat (600) @(negedge clk);
    exp_servo(10);
    wait_servo(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not complete, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
